// File: rtl/pal_lut_pkg.sv
// Shared types and constants for the palette-to-RGB converter.
// Holds the field slices, FSM state encoding and LUT limits.
package pal_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_R    = 2'd1,
        ST_G    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    localparam logic [4:0] LUT_MAX_IN = 5'd24;
    localparam logic [7:0] MAX_LEVEL  = 8'd255;

    function automatic logic [4:0] field_r(input logic [14:0] c);
        return c[14:10];
    endfunction

    function automatic logic [4:0] field_g(input logic [14:0] c);
        return c[9:5];
    endfunction

    function automatic logic [4:0] field_b(input logic [14:0] c);
        return c[4:0];
    endfunction

endpackage

// File: rtl/pal_lut_seq_lut.sv
// 5-bit to 8-bit level converter: linear shift or truncating scale to 0..255 over 0..24.
// Purely combinational; the caller muxes the field into it.
module pal_lut_seq_lut
    import pal_lut_pkg::*;
(
    input  logic       mode,
    input  logic [4:0] lvl_in,
    output logic [7:0] lvl_out
);

    // Levels above LUT_MAX_IN are out of the scaled range and pin to full scale.
    function automatic logic [7:0] scale_level(input logic [4:0] f);
        logic [12:0] prod;
        if (f > LUT_MAX_IN) begin
            return MAX_LEVEL;
        end
        prod = 13'(f) * 13'd255;
        return 8'(prod / 13'd24);
    endfunction

    always_comb begin
        if (mode) begin
            lvl_out = {lvl_in, 3'b000};
        end else begin
            lvl_out = scale_level(lvl_in);
        end
    end

endmodule

// File: rtl/pal_lut_seq.sv
// Palette word to 24-bit RGB converter: one shared LUT walked over R, G, B by a small FSM,
// results buffered in a circular output FIFO with valid/ready on both sides.
module pal_lut_seq
    import pal_lut_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_color,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic        busy
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic              ready_en;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     fifo_free;
    logic              push;
    logic              pop;
    logic              rdy_idle;
    logic              rdy_b;
    logic              in_ready_c;
    logic              accept;
    logic [14:0]       word_p0;
    logic              mode_p0;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [4:0]        lut_in;
    logic [7:0]        lut_out;
    logic [23:0]       mem [OUT_DEPTH];

    pal_lut_seq_lut u_lut (
        .mode    (mode_p0),
        .lvl_in  (lut_in),
        .lvl_out (lut_out)
    );

    assign fifo_free = CW'(OUT_DEPTH) - count;
    // Accepting from B needs room for the word being pushed now plus the new one.
    assign rdy_idle  = ready_en && !clr && (fifo_free >= CW'(1));
    assign rdy_b     = !clr && (fifo_free >= CW'(2));

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        push       = 1'b0;
        lut_in     = 5'd0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = rdy_idle;
                if (in_valid && rdy_idle) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                lut_in  = field_r(word_p0);
                state_d = ST_G;
            end
            ST_G: begin
                lut_in  = field_g(word_p0);
                state_d = ST_B;
            end
            ST_B: begin
                lut_in     = field_b(word_p0);
                push       = 1'b1;
                in_ready_c = rdy_b;
                state_d    = (in_valid && rdy_b) ? ST_R : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            push    = 1'b0;
        end
    end

    assign in_ready  = in_ready_c;
    assign accept    = in_valid && in_ready_c;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_rgb   = out_valid ? mem[rd_ptr] : 24'd0;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Stage p0: latched word; stage p1: captured R/G levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_p0 <= '0;
            mode_p0 <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
        end else begin
            if (accept) begin
                word_p0 <= in_color;
                mode_p0 <= in_mode;
            end
            if (state_q == ST_R) r_q <= lut_out;
            if (state_q == ST_G) g_q <= lut_out;
        end
    end

    // Stage p2: FIFO storage; emptiness is tracked by count, so contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {r_q, g_q, lut_out};
        end
    end

endmodule

// File: tb/tb_pal_lut_seq.sv
// Bench for pal_lut_seq: directed LUT vectors plus randomized traffic scored against a
// queue-based reference built from the colour conversion rules.
module tb_pal_lut_seq;

    localparam int OUT_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_color = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_rgb;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    pal_lut_seq #(.OUT_DEPTH(OUT_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_color  (in_color),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rgb   (out_rgb),
        .busy      (busy)
    );

    function automatic logic [7:0] ref_level(input logic [4:0] f, input logic m);
        int v;
        if (m) return {f, 3'b000};
        if (int'(f) >= 25) return 8'd255;
        v = int'(f) * 255 / 24;
        return 8'(v);
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [14:0] c, input logic m);
        return {ref_level(c[14:10], m), ref_level(c[9:5], m), ref_level(c[4:0], m)};
    endfunction

    // Scoreboard: accepted words enter the queue, popped outputs must match in order.
    always @(negedge clk) begin
        if (!rst_n || clr) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_order: unexpected output %h, expected none", out_rgb);
                end else begin
                    if (out_rgb !== exp_q[0]) begin
                        fails++;
                        $display("FAIL out_order: got %h, want %h", out_rgb, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_rgb(in_color, in_mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || out_rgb !== 24'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b rgb=%h busy=%b ready=%b, want 0/0/0/0",
                     out_valid, out_rgb, busy, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, want 0 before first edge", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_rgb !== 24'd0) begin
            fails++;
            $display("FAIL reset_after_edge: ready=%b busy=%b valid=%b rgb=%h, want 1/0/0/0",
                     in_ready, busy, out_valid, out_rgb);
        end
    endtask

    task automatic test_lut_vectors();
        logic [14:0] colors [3];
        logic        modes  [3];
        logic [23:0] wants  [3];
        int lat;
        colors[0] = {5'd1, 5'd12, 5'd24}; modes[0] = 1'b0; wants[0] = 24'h0A7FFF;
        colors[1] = 15'h7FFF;             modes[1] = 1'b0; wants[1] = 24'hFFFFFF;
        colors[2] = {5'd31, 5'd1, 5'd0};  modes[2] = 1'b1; wants[2] = 24'hF80800;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_color = colors[i]; in_mode = modes[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            in_color = 15'($urandom);
            in_mode  = 1'($urandom);
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            checks++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL lut_latency[%0d]: got %0d edges, want 3", i, lat);
            end
            checks++;
            if (out_rgb !== wants[i]) begin
                fails++;
                $display("FAIL lut_value[%0d]: got %h, want %h", i, out_rgb, wants[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL lut_pop[%0d]: out_valid got %b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int n;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_color = 15'($urandom); in_mode = 1'($urandom); in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (acc !== OUT_DEPTH) begin
            fails++;
            $display("FAIL bp_stored: got %0d accepts, want %0d", acc, OUT_DEPTH);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_state: ready=%b busy=%b valid=%b, want 0/0/1", in_ready, busy, out_valid);
        end
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: %0d words left, valid=%b, want 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n, cyc, last, dr;
        logic acc;
        logic [31:0] tmp;
        n = 0; cyc = 0; last = 0;
        out_ready = 1'b1;
        tmp = $urandom;
        in_color = {tmp[9:0], 5'(0)}; in_mode = tmp[20]; in_valid = 1'b1;
        while (n < 8 && cyc < 60) begin
            acc = in_ready;
            tick();
            if (acc) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last !== 3) begin
                        fails++;
                        $display("FAIL b2b_gap[%0d]: got %0d cycles, want 3", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
                tmp = $urandom;
                in_color = {tmp[9:0], 5'(n)}; in_mode = tmp[20];
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d accepts, want 8", n);
        end
        dr = 0;
        while ((exp_q.size() != 0 || out_valid) && dr < 20) begin
            tick();
            dr++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: got %0d words left, want 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int acc, cyc, dr;
        acc = 0; cyc = 0;
        while (acc < 12 && cyc < 300) begin
            in_color  = 15'($urandom);
            in_mode   = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (acc !== 12) begin
            fails++;
            $display("FAIL rand_accepts: got %0d, want 12", acc);
        end
        dr = 0;
        while ((exp_q.size() != 0 || out_valid) && dr < 20) begin
            tick();
            dr++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rand_drain: %0d words left, valid=%b, want 0/0", exp_q.size(), out_valid);
        end
    endtask

    // Leaves one word in the FIFO and a second one sitting in the G state.
    task automatic setup_mid_word(input string tag);
        int n;
        out_ready = 1'b0;
        in_color = 15'($urandom); in_mode = 1'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        in_color = 15'($urandom); in_mode = 1'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_setup: valid=%b busy=%b, want 1/1", tag, out_valid, busy);
        end
    endtask

    task automatic test_clr();
        setup_mid_word("clr");
        clr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_ready: got %b, want 0", in_ready);
        end
        tick();
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_rgb !== 24'd0) begin
            fails++;
            $display("FAIL clr_after: valid=%b busy=%b rgb=%h, want 0/0/0", out_valid, busy, out_rgb);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL clr_quiet: valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end

        setup_mid_word("rst");
        rst_n = 1'b0;
        #6;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_rgb !== 24'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: valid=%b busy=%b rgb=%h ready=%b, want 0/0/0/1",
                     out_valid, busy, out_rgb, in_ready);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_quiet: valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lut_vectors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_clr();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
